alu_exec_pipe: RTL and testbench
================================

Name: alu_exec_pipe

Overview:
- Parametrised successor of the single-cycle ALU op modules: one pipelined execute unit covering instr IDs 1–12, with its own internal register file.
- Accepts decoded instructions through a valid/ready handshake.
- Reads operands from the register file (with forwarding), computes one cycle later and presents the result.
- Writes the result back to the register file when the downstream consumer accepts it.
- Sits between the decode stage and the processor's writeback/PC logic.

Parameters:
- DATA_W, 32, datapath and register width (≥16).
- REG_COUNT, 32, number of architectural registers (power of 2).
- ADDR_W, $clog2(REG_COUNT), register index width.
- OP_W, 4, instr ID width.
- ZERO_REG, 1, if 1 then register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  unit can accept this cycle
- instr_id  in  OP_W  1 add, 2 sub, 3 addu, 4 subu, 5 addi, 6 addiu, 7 and, 8 or, 9 andi, 10 ori, 11 sll, 12 srl
- rs  in  ADDR_W  operand A register
- rt  in  ADDR_W  operand B register (R-type)
- rd  in  ADDR_W  destination register
- imm  in  16  immediate (I-type IDs 5, 6, 9, 10)
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- result  out  DATA_W  computed value
- out_rd  out  ADDR_W  destination of held result
- ovf  out  1  signed overflow on held result (IDs 1, 2, 5)
- illegal  out  1  held entry had an unsupported instr_id
- dbg_addr  in  ADDR_W  debug read index
- dbg_data  out  DATA_W  combinational read of regfile[dbg_addr], no forwarding

Behaviour:
- Reset (synchronous, active-high, clk):
  - out_valid=0, result=0, out_rd=0, ovf=0, illegal=0.
  - All registers cleared to 0.
  - in_ready=1 the cycle after reset deasserts.
  - A held result is discarded and is not written back.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Accept when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - Accept and transfer can occur in the same cycle (full throughput, 1 instr/cycle).
- Latency: instruction accepted at edge N appears at out_valid/result after edge N (visible in cycle N+1). Outputs are held stable while out_valid && !out_ready.
- Operand read:
  - A = reg[rs]; B = reg[rt] for R-type.
  - B = sign-extended imm for IDs 5, 6.
  - B = zero-extended imm for IDs 9, 10.
- Forwarding: if the held entry transfers in the same cycle a new instruction is accepted, and it writes (no ovf, not illegal, out_rd≠0 when ZERO_REG), then a matching rs/rt reads the held result instead of the register file.
- Arithmetic: all results are truncated to DATA_W (mod 2^DATA_W).
  - add/sub/addi: signed overflow sets ovf=1.
  - addu/subu/addiu: never set ovf.
- Shifts: amount = B[$clog2(DATA_W)-1:0]; upper bits of B are ignored.
  - sll fills with zeros.
  - srl is logical (fills with zeros).
- Illegal instr_id (0, 13–15): accepted; result=0, illegal=1, no writeback.
- Writeback: on transfer, reg[out_rd] <= result unless ovf=1, illegal=1, or (ZERO_REG && out_rd==0).
- Backpressure: a new accept is blocked while out_valid && !out_ready. in_valid may toggle freely; inputs are sampled only on accept.

Test Plan:
- Reset, then check dbg_data for reg0..REG_COUNT-1 → all 0. Check out_valid=0 and in_ready=1.
- addi r1,r0,0x7FFF then addi r1,r1,1 back-to-back, out_ready=1 → second result=0x8000, ovf=0 (forwarding used); dbg reg1=0x8000.
- Set reg2=0x7FFFFFFF; then add r3,r2,r2 → result 0xFFFFFFFE, ovf=1, reg3 unchanged. Then addu r3,r2,r2 → reg3=0xFFFFFFFE, ovf=0.
- andi with imm=0xFFFF on 0xDEADBEEF → 0x0000BEEF. addiu with imm=0xFFFF on 5 → 4. sll 1 by B=0x21 → 2. srl 0x80000000 by 31 → 1.
- Hold out_ready=0 for 3 cycles with a result held → in_ready=0, result and out_rd stable, reg not written; release → exactly one writeback and next accept.
- instr_id=13 → illegal=1, result=0, no write. Write to rd=0 → reg0 stays 0. Assert reset while out_valid=1 → held write is dropped.

Source files
------------

// File: rtl/alu_exec_pipe.sv
// Pipelined single-issue ALU execute unit with an internal register file.
// One registered output stage; results retire to the register file on output transfer.
module alu_exec_pipe #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned ADDR_W    = $clog2(REG_COUNT),
  parameter int unsigned OP_W      = 4,
  parameter int unsigned ZERO_REG  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   instr_id,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [15:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] out_rd,
  output logic              ovf,
  output logic              illegal,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned ShW = $clog2(DATA_W);

  localparam logic [OP_W-1:0] IdAdd   = OP_W'(1);
  localparam logic [OP_W-1:0] IdSub   = OP_W'(2);
  localparam logic [OP_W-1:0] IdAddu  = OP_W'(3);
  localparam logic [OP_W-1:0] IdSubu  = OP_W'(4);
  localparam logic [OP_W-1:0] IdAddi  = OP_W'(5);
  localparam logic [OP_W-1:0] IdAddiu = OP_W'(6);
  localparam logic [OP_W-1:0] IdAnd   = OP_W'(7);
  localparam logic [OP_W-1:0] IdOr    = OP_W'(8);
  localparam logic [OP_W-1:0] IdAndi  = OP_W'(9);
  localparam logic [OP_W-1:0] IdOri   = OP_W'(10);
  localparam logic [OP_W-1:0] IdSll   = OP_W'(11);
  localparam logic [OP_W-1:0] IdSrl   = OP_W'(12);

  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic [DATA_W-1:0] regs_d [REG_COUNT];

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [ADDR_W-1:0] out_rd_q, out_rd_d;
  logic              ovf_q, ovf_d;
  logic              illegal_q, illegal_d;

  logic              accept, xfer, wb_en;
  logic [DATA_W-1:0] op_a, op_b, rf_b, sum, diff, alu_res;
  logic [ShW-1:0]    shamt;
  logic              alu_ovf, alu_ill;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;
  assign wb_en    = xfer && !ovf_q && !illegal_q && !((ZERO_REG != 0) && (out_rd_q == '0));

  // The retiring entry writes on the same edge this instruction is sampled, so bypass it.
  assign op_a = (wb_en && (rs == out_rd_q)) ? result_q : regs_q[rs];
  assign rf_b = (wb_en && (rt == out_rd_q)) ? result_q : regs_q[rt];

  always_comb begin
    op_b = rf_b;
    if (instr_id == IdAddi || instr_id == IdAddiu) begin
      op_b = {{(DATA_W-16){imm[15]}}, imm};
    end else if (instr_id == IdAndi || instr_id == IdOri) begin
      op_b = {{(DATA_W-16){1'b0}}, imm};
    end
  end

  assign sum   = op_a + op_b;
  assign diff  = op_a - op_b;
  assign shamt = op_b[ShW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (instr_id)
      IdAdd, IdAddi: begin
        alu_res = sum;
        alu_ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);
      end
      IdAddu, IdAddiu: alu_res = sum;
      IdSub: begin
        alu_res = diff;
        alu_ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != op_a[DATA_W-1]);
      end
      IdSubu:        alu_res = diff;
      IdAnd, IdAndi: alu_res = op_a & op_b;
      IdOr, IdOri:   alu_res = op_a | op_b;
      IdSll:         alu_res = op_a << shamt;
      IdSrl:         alu_res = op_a >> shamt;
      default:       alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    out_rd_d    = out_rd_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      out_rd_d    = rd;
      ovf_d       = alu_ovf;
      illegal_d   = alu_ill;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_en) begin
      regs_d[out_rd_q] = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_rd_q    <= '0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_rd_q    <= out_rd_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_rd    = out_rd_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;
  assign dbg_data  = ((ZERO_REG != 0) && (dbg_addr == '0)) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Self-checking bench for alu_exec_pipe: vector table driven through a scoreboard,
// plus backpressure and reset-while-holding sequences.
module tb_alu_exec_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  instr_id;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  out_rd;
  logic        ovf;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  alu_exec_pipe dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr_id (instr_id),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .imm      (imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .out_rd   (out_rd),
    .ovf      (ovf),
    .illegal  (illegal),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] res;
    logic        ovf;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ovf;
    logic        ill;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  exp_t        cur_exp;
  logic [31:0] model_rf[32];
  int          n_pass = 0;
  int          n_total = 0;
  int          xfer_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] id, input logic [4:0] s, input logic [4:0] t,
                              input logic [4:0] d, input logic [15:0] im,
                              input logic [31:0] r, input logic o, input logic il);
    vec_t v;
    v.id = id; v.rs = s; v.rt = t; v.rd = d; v.imm = im; v.res = r; v.ovf = o; v.ill = il;
    return v;
  endfunction

  // Scoreboard: push on accept, pop/compare on transfer; both decided at the negedge
  // before the edge where they occur.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      for (int i = 0; i < 32; i++) model_rf[i] = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got rd=%0d result=0x%08h expected no output",
                   out_rd, result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_result", result, e.res);
          check("out_rd", 32'(out_rd), 32'(e.rd));
          check("out_flags", {30'd0, ovf, illegal}, {30'd0, e.ovf, e.ill});
          if (!e.ovf && !e.ill && e.rd != 5'd0) model_rf[e.rd] = e.res;
          xfer_cnt++;
        end
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  // Called just after a posedge; returns just after the posedge on which it was accepted.
  task automatic issue(input vec_t v);
    bit ok;
    instr_id = v.id; rs = v.rs; rt = v.rt; rd = v.rd; imm = v.imm;
    cur_exp.res = v.res; cur_exp.rd = v.rd; cur_exp.ovf = v.ovf; cur_exp.ill = v.ill;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic dump_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check($sformatf("%s_reg%0d", tag, i), dbg_data, model_rf[i]);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    instr_id = '0; rs = '0; rt = '0; rd = '0; imm = '0; dbg_addr = '0;
    cur_exp = '{res: '0, rd: '0, ovf: 1'b0, ill: 1'b0};
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_result", result, 32'd0);
    dump_regs("rst");

    // id, rs, rt, rd, imm, expected result, ovf, illegal
    vecs.push_back(mk(4'd5,  5'd0,  5'd0,  5'd1,  16'h7FFF, 32'h0000_7FFF, 1'b0, 1'b0));
    vecs.push_back(mk(4'd5,  5'd1,  5'd0,  5'd1,  16'h0001, 32'h0000_8000, 1'b0, 1'b0));
    vecs.push_back(mk(4'd10, 5'd0,  5'd0,  5'd2,  16'h7FFF, 32'h0000_7FFF, 1'b0, 1'b0));
    vecs.push_back(mk(4'd5,  5'd0,  5'd0,  5'd4,  16'd16,   32'd16,        1'b0, 1'b0));
    vecs.push_back(mk(4'd11, 5'd2,  5'd4,  5'd2,  16'h0,    32'h7FFF_0000, 1'b0, 1'b0));
    vecs.push_back(mk(4'd10, 5'd2,  5'd0,  5'd2,  16'hFFFF, 32'h7FFF_FFFF, 1'b0, 1'b0));
    vecs.push_back(mk(4'd1,  5'd2,  5'd2,  5'd3,  16'h0,    32'hFFFF_FFFE, 1'b1, 1'b0));
    vecs.push_back(mk(4'd3,  5'd2,  5'd2,  5'd3,  16'h0,    32'hFFFF_FFFE, 1'b0, 1'b0));
    vecs.push_back(mk(4'd10, 5'd0,  5'd0,  5'd5,  16'hDEAD, 32'h0000_DEAD, 1'b0, 1'b0));
    vecs.push_back(mk(4'd11, 5'd5,  5'd4,  5'd5,  16'h0,    32'hDEAD_0000, 1'b0, 1'b0));
    vecs.push_back(mk(4'd10, 5'd5,  5'd0,  5'd5,  16'hBEEF, 32'hDEAD_BEEF, 1'b0, 1'b0));
    vecs.push_back(mk(4'd9,  5'd5,  5'd0,  5'd6,  16'hFFFF, 32'h0000_BEEF, 1'b0, 1'b0));
    vecs.push_back(mk(4'd5,  5'd0,  5'd0,  5'd7,  16'd5,    32'd5,         1'b0, 1'b0));
    vecs.push_back(mk(4'd6,  5'd7,  5'd0,  5'd8,  16'hFFFF, 32'd4,         1'b0, 1'b0));
    vecs.push_back(mk(4'd5,  5'd0,  5'd0,  5'd9,  16'd1,    32'd1,         1'b0, 1'b0));
    vecs.push_back(mk(4'd5,  5'd0,  5'd0,  5'd10, 16'h21,   32'h21,        1'b0, 1'b0));
    vecs.push_back(mk(4'd11, 5'd9,  5'd10, 5'd11, 16'h0,    32'd2,         1'b0, 1'b0));
    vecs.push_back(mk(4'd10, 5'd0,  5'd0,  5'd12, 16'h8000, 32'h0000_8000, 1'b0, 1'b0));
    vecs.push_back(mk(4'd11, 5'd12, 5'd4,  5'd12, 16'h0,    32'h8000_0000, 1'b0, 1'b0));
    vecs.push_back(mk(4'd5,  5'd0,  5'd0,  5'd13, 16'd31,   32'd31,        1'b0, 1'b0));
    vecs.push_back(mk(4'd12, 5'd12, 5'd13, 5'd14, 16'h0,    32'd1,         1'b0, 1'b0));
    vecs.push_back(mk(4'd2,  5'd7,  5'd9,  5'd15, 16'h0,    32'd4,         1'b0, 1'b0));
    vecs.push_back(mk(4'd4,  5'd9,  5'd7,  5'd16, 16'h0,    32'hFFFF_FFFC, 1'b0, 1'b0));
    vecs.push_back(mk(4'd7,  5'd5,  5'd6,  5'd17, 16'h0,    32'h0000_BEEF, 1'b0, 1'b0));
    vecs.push_back(mk(4'd8,  5'd6,  5'd7,  5'd18, 16'h0,    32'h0000_BEEF, 1'b0, 1'b0));
    vecs.push_back(mk(4'd2,  5'd12, 5'd9,  5'd19, 16'h0,    32'h7FFF_FFFF, 1'b1, 1'b0));
    vecs.push_back(mk(4'd5,  5'd2,  5'd0,  5'd20, 16'd1,    32'h8000_0000, 1'b1, 1'b0));
    vecs.push_back(mk(4'd13, 5'd5,  5'd5,  5'd21, 16'h0,    32'd0,         1'b0, 1'b1));
    vecs.push_back(mk(4'd0,  5'd5,  5'd5,  5'd22, 16'h0,    32'd0,         1'b0, 1'b1));
    vecs.push_back(mk(4'd15, 5'd5,  5'd5,  5'd26, 16'h0,    32'd0,         1'b0, 1'b1));
    vecs.push_back(mk(4'd5,  5'd7,  5'd0,  5'd0,  16'd0,    32'd5,         1'b0, 1'b0));
    vecs.push_back(mk(4'd6,  5'd2,  5'd0,  5'd27, 16'd1,    32'h8000_0000, 1'b0, 1'b0));
    vecs.push_back(mk(4'd12, 5'd5,  5'd10, 5'd28, 16'h0,    32'h6F56_DF77, 1'b0, 1'b0));

    @(posedge clk); #1;
    foreach (vecs[i]) issue(vecs[i]);
    in_valid = 1'b0;
    drain();
    dump_regs("tbl");
    check("reg3_after_addu", model_rf[3], 32'hFFFF_FFFE);

    // Backpressure: hold a result for 3 cycles while another instruction waits.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(mk(4'd5, 5'd0, 5'd0, 5'd23, 16'h55, 32'h55, 1'b0, 1'b0));
    instr_id = 4'd5; rs = 5'd0; rt = 5'd0; rd = 5'd24; imm = 16'h66;
    cur_exp = '{res: 32'h66, rd: 5'd24, ovf: 1'b0, ill: 1'b0};
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dbg_addr = 5'd23;
      #1;
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_result", result, 32'h55);
      check("bp_out_rd", 32'(out_rd), 32'd23);
      check("bp_no_write", dbg_data, 32'd0);
    end
    @(posedge clk); #1;
    xfer_cnt = 0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    check("bp_xfer_count", 32'(xfer_cnt), 32'd2);
    dbg_addr = 5'd23; #1;
    check("bp_reg23", dbg_data, 32'h55);
    dbg_addr = 5'd24; #1;
    check("bp_reg24", dbg_data, 32'h66);

    // Reset while a result is held: the held write must be dropped.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(mk(4'd5, 5'd0, 5'd0, 5'd25, 16'h77, 32'h77, 1'b0, 1'b0));
    in_valid = 1'b0;
    check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    dump_regs("rst2");
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
